// File: rtl/apb_cmd_master.sv
// apb_cmd_master
// Single-outstanding APB master. A command accepted on the valid/ready port
// becomes one APB transfer (SETUP, then ACCESS until PREADY). The result comes
// back on the valid/ready response port. A wait counter bounds the ACCESS
// phase, so a slave that never raises PREADY produces an error response
// instead of hanging the bus.
module apb_cmd_master #(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 8,
  parameter int TIMEOUT   = 16
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  // command port
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [ADDRWIDTH-1:0] cmd_addr,
  input  logic [DATAWIDTH-1:0] cmd_wdata,
  // response port
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATAWIDTH-1:0] rsp_rdata,
  output logic                 rsp_err,
  // APB master side
  output logic                 PSEL,
  output logic                 PENABLE,
  output logic                 PWRITE,
  output logic [ADDRWIDTH-1:0] PADDR,
  output logic [DATAWIDTH-1:0] PWDATA,
  input  logic [DATAWIDTH-1:0] PRDATA,
  input  logic                 PREADY
);

  localparam int CNTW = $clog2(TIMEOUT) + 1;
  // Counter value seen during the last ACCESS cycle the slave is allowed.
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [CNTW-1:0]        cnt;
  logic [CNTW-1:0]        cnt_nxt;
  logic                   timeout_hit;

  logic                   psel_nxt;
  logic                   penable_nxt;
  logic                   pwrite_nxt;
  logic [ADDRWIDTH-1:0]   paddr_nxt;
  logic [DATAWIDTH-1:0]   pwdata_nxt;
  logic                   rsp_valid_nxt;
  logic [DATAWIDTH-1:0]   rsp_rdata_nxt;
  logic                   rsp_err_nxt;

  // The only combinational output: a new command can be taken only when idle.
  assign cmd_ready   = (state == IDLE);
  assign timeout_hit = (cnt == CNT_LAST);

  // State register; reset abandons any transfer in flight.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; PREADY and the timeout both end ACCESS.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_valid)               state_nxt = SETUP;
      SETUP:                                state_nxt = ACCESS;
      ACCESS:  if (PREADY || timeout_hit)   state_nxt = RESP;
      RESP:    if (rsp_valid && rsp_ready)  state_nxt = IDLE;
      default:                              state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs and the wait counter.
  always_comb begin
    psel_nxt      = PSEL;
    penable_nxt   = PENABLE;
    pwrite_nxt    = PWRITE;
    paddr_nxt     = PADDR;
    pwdata_nxt    = PWDATA;
    rsp_valid_nxt = rsp_valid;
    rsp_rdata_nxt = rsp_rdata;
    rsp_err_nxt   = rsp_err;
    cnt_nxt       = cnt;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          psel_nxt    = 1'b1;
          penable_nxt = 1'b0;
          pwrite_nxt  = cmd_write;
          paddr_nxt   = cmd_addr;
          pwdata_nxt  = cmd_wdata;
        end
      end
      SETUP: begin
        penable_nxt = 1'b1;
        cnt_nxt     = '0;
      end
      ACCESS: begin
        // PREADY is checked first so a completion in the last allowed
        // cycle still counts as success.
        if (PREADY) begin
          rsp_rdata_nxt = PWRITE ? '0 : PRDATA;
          rsp_err_nxt   = 1'b0;
          rsp_valid_nxt = 1'b1;
          psel_nxt      = 1'b0;
          penable_nxt   = 1'b0;
        end else if (timeout_hit) begin
          rsp_rdata_nxt = '0;
          rsp_err_nxt   = 1'b1;
          rsp_valid_nxt = 1'b1;
          psel_nxt      = 1'b0;
          penable_nxt   = 1'b0;
        end else begin
          cnt_nxt = cnt + CNTW'(1);
        end
      end
      RESP: begin
        // Data and status stay put after the handshake; only valid drops.
        if (rsp_ready) rsp_valid_nxt = 1'b0;
      end
      default: begin
        psel_nxt      = 1'b0;
        penable_nxt   = 1'b0;
        rsp_valid_nxt = 1'b0;
      end
    endcase
  end

  // Output and counter registers; reset forces the bus idle immediately.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      cnt       <= '0;
    end else begin
      PSEL      <= psel_nxt;
      PENABLE   <= penable_nxt;
      PWRITE    <= pwrite_nxt;
      PADDR     <= paddr_nxt;
      PWDATA    <= pwdata_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_rdata <= rsp_rdata_nxt;
      rsp_err   <= rsp_err_nxt;
      cnt       <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: directed scenarios followed by random commands.
// Expected responses come from a transaction-level model (memory array,
// wait-state rule, latency formula) and are checked by an independent monitor.
module tb_apb_cmd_master;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int TO = 16;

  logic          PCLK = 1'b0;
  logic          PRESET = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          PSEL, PENABLE, PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA = '0;
  logic          PREADY = 1'b0;

  apb_cmd_master #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            waits;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
    int            exp_rise;
  } txn_t;

  txn_t          sb_q[$];
  txn_t          slv_q[$];
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] slv_mem [256];
  int            compared = 0;
  int            mismatched = 0;
  int            force_stall = 0;
  bit            rnd_ready = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: actual 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Slave model: memory plus a per-transfer wait-state count.
  int s_n = 0;
  int s_setup = 0;
  bit s_act = 1'b0;
  always @(negedge PCLK) begin
    if (PRESET) begin
      s_act = 1'b0; s_n = 0; s_setup = 0; PREADY = 1'b0;
    end else if (PSEL && !PENABLE) begin
      s_act = 1'b1; s_setup++; s_n = 0;
      PREADY = 1'($urandom_range(0, 1)); PRDATA = $urandom;
    end else if (PSEL && PENABLE) begin
      if (slv_q.size() == 0) begin
        compared++; mismatched++;
        $display("FAIL slave_unexpected_access: actual PSEL=1, required no transfer (cycle %0d)", cyc);
        PREADY = 1'b0;
      end else begin
        chk("paddr_stable", PADDR, slv_q[0].addr);
        chk("pwrite_stable", PWRITE, slv_q[0].wr);
        chk("pwdata_stable", PWDATA, slv_q[0].wdata);
        if (s_n == slv_q[0].waits) begin
          PREADY = 1'b1;
          if (PWRITE) slv_mem[PADDR] = PWDATA;
          else        PRDATA = slv_mem[PADDR];
        end else begin
          PREADY = 1'b0; PRDATA = $urandom;
        end
      end
      s_n++;
    end else begin
      if (s_act && slv_q.size() > 0) begin
        chk("access_cycles", s_n, (slv_q[0].waits < TO ? slv_q[0].waits : TO - 1) + 1);
        chk("setup_cycles", s_setup, 1);
        void'(slv_q.pop_front());
      end
      s_act = 1'b0; s_setup = 0;
      PREADY = 1'($urandom_range(0, 1)); PRDATA = $urandom;
    end
  end

  // Response consumer: optional forced stall, otherwise random or always ready.
  always @(negedge PCLK) begin
    if (rsp_valid && force_stall > 0) begin
      rsp_ready = 1'b0; force_stall--;
    end else begin
      rsp_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Monitor: protocol rules and response scoreboard.
  bit m_prev = 1'b0;
  int m_psel_run = 0;
  always @(negedge PCLK) begin
    #1;
    if (PRESET) begin
      m_prev = 1'b0; m_psel_run = 0;
    end else begin
      chk("penable_without_psel", PENABLE & ~PSEL, 0);
      if (PSEL) begin
        m_psel_run++;
        chk("psel_run_bound", (m_psel_run <= TO + 1), 1);
      end else begin
        m_psel_run = 0;
      end
      if (rsp_valid) begin
        chk("cmd_ready_in_resp", cmd_ready, 0);
        if (sb_q.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL spurious_rsp: actual rsp_valid=1, required 0 (cycle %0d)", cyc);
        end else begin
          if (!m_prev) chk("rsp_rise_cycle", cyc, sb_q[0].exp_rise);
          chk("rsp_rdata", rsp_rdata, sb_q[0].exp_rdata);
          chk("rsp_err", rsp_err, sb_q[0].exp_err);
          if (rsp_ready) void'(sb_q.pop_front());
        end
      end
      m_prev = rsp_valid;
    end
  end

  // Issue one command; the reference model predicts the response on acceptance.
  task automatic send(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                      input int waits);
    txn_t t;
    int   guard;
    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    guard = 0;
    while (!cmd_ready && guard < 400) begin
      @(negedge PCLK);
      guard++;
    end
    if (!cmd_ready) begin
      compared++; mismatched++;
      $display("FAIL cmd_accept: actual cmd_ready=0 for 400 cycles, required 1");
      cmd_valid = 1'b0;
      return;
    end
    t.wr        = wr;
    t.addr      = addr;
    t.wdata     = wdata;
    t.waits     = waits;
    t.exp_err   = (waits >= TO);
    t.exp_rdata = (wr || t.exp_err) ? '0 : ref_mem[addr];
    if (wr && !t.exp_err) ref_mem[addr] = wdata;
    t.exp_rise  = cyc + 3 + (waits < TO ? waits : TO - 1);
    sb_q.push_back(t);
    slv_q.push_back(t);
    @(negedge PCLK);
    cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = AW'($urandom); cmd_wdata = $urandom;
  endtask

  initial begin
    logic [DW-1:0] v;
    int            r;
    int            w;
    int            guard;
    for (int i = 0; i < 256; i++) begin
      v = $urandom;
      ref_mem[i] = v;
      slv_mem[i] = v;
    end

    // Reset values while reset is held.
    repeat (3) @(negedge PCLK);
    #1;
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_pwrite", PWRITE, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_pwdata", PWDATA, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    #1 PRESET = 1'b0;
    @(negedge PCLK);
    #1 chk("cmd_ready_after_reset", cmd_ready, 1);

    // Zero-wait write then read back.
    send(1'b1, 8'h10, 32'hDEADBEEF, 0);
    send(1'b0, 8'h10, 32'h0, 0);
    // Read with three wait states.
    send(1'b1, 8'h3F, 32'h12345678, 0);
    send(1'b0, 8'h3F, 32'h0, 3);
    // Timeouts: stuck slave for a read and a write (write must not land).
    send(1'b0, 8'h05, 32'h0, 1000);
    send(1'b1, 8'h06, 32'hA5A5A5A5, TO);
    send(1'b0, 8'h06, 32'h0, 0);
    // PREADY in the last allowed ACCESS cycle wins over the timeout.
    send(1'b0, 8'h10, 32'h0, TO - 1);
    // Consumer stalls five cycles; next command must wait.
    force_stall = 5;
    send(1'b0, 8'h3F, 32'h0, 0);
    send(1'b1, 8'h11, 32'h0BADF00D, 1);
    chk("stall_consumed", force_stall, 0);

    // Reset during ACCESS of a write to 0x20.
    send(1'b1, 8'h20, 32'hCAFEF00D, 1000);
    repeat (4) @(negedge PCLK);
    #1 chk("psel_before_reset", PSEL, 1);
    #1 PRESET = 1'b1;
    #1;
    chk("midrst_psel", PSEL, 0);
    chk("midrst_penable", PENABLE, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_paddr", PADDR, 0);
    chk("midrst_pwdata", PWDATA, 0);
    chk("midrst_pwrite", PWRITE, 0);
    chk("midrst_rsp_rdata", rsp_rdata, 0);
    chk("midrst_cmd_ready", cmd_ready, 1);
    sb_q.delete();
    slv_q.delete();
    @(negedge PCLK);
    #2 PRESET = 1'b0;
    send(1'b0, 8'h20, 32'h0, 0);
    send(1'b0, 8'h11, 32'h0, 2);

    // Random traffic.
    rnd_ready = 1'b1;
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      if (r < 6)       w = $urandom_range(0, 3);
      else if (r == 6) w = TO - 1;
      else if (r == 7) w = TO;
      else if (r == 8) w = TO + $urandom_range(1, 5);
      else             w = $urandom_range(4, TO - 2);
      send(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom, w);
      repeat ($urandom_range(0, 2)) @(negedge PCLK);
    end

    // Drain outstanding responses.
    rnd_ready = 1'b0;
    guard = 0;
    while (sb_q.size() != 0 && guard < 200) begin
      @(negedge PCLK);
      guard++;
    end
    repeat (2) @(negedge PCLK);
    chk("scoreboard_drained", sb_q.size(), 0);
    chk("slave_queue_drained", slv_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
